dpe_eth_rx_classifier: RTL and testbench

- Sits directly downstream of the 1G MAC RX FIFO (128-bit AXI-Stream, little-endian byte lanes, byte 0 in tdata[7:0]).
- Buffers the first three beats of each frame and parses the Ethernet, IPv4 and UDP headers.
- Drops frames that fail the destination-MAC filter; forwards all other frames unchanged, with a class tag in tuser, to the data-plane engine.

---
 rtl/dpe_eth_rx_classifier.sv | 167 ++++++++++++++++
 tb/tb_dpe_eth_rx_classifier.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpe_eth_rx_classifier.sv
// Ethernet RX classifier: holds the first 3 beats of a frame, parses Eth/IPv4/UDP,
// drops frames that fail the dst-MAC filter and forwards the rest with a class tag.
// Latency: first output beat one cycle after DECIDE (>= 4 cycles for 3+ beat frames), then 1 beat/cycle.
// Backpressure: s_tready is low in DECIDE and while the buffer is full with no output pop.
// Ports: clk/rst_n (async active-low); s_* AXIS input from the MAC RX FIFO (s_tuser = bad-frame flag on tlast);
//        m_* AXIS output, m_tuser = {class[1:0], bad}; drop_cnt = saturating count of filtered frames.
module dpe_eth_rx_classifier #(
  parameter logic [47:0] LOCAL_MAC   = 48'h0000_0000_0000,
  parameter logic [15:0] WG_UDP_PORT = 16'd51820,
  parameter bit          FILTER_EN   = 1'b1,
  parameter int          DATA_WIDTH  = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  input  logic                    s_tuser,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic [2:0]              m_tuser,
  output logic [15:0]             drop_cnt
);

  localparam int KW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {COLLECT, DECIDE, FORWARD, DROP} state_t;
  state_t state, state_nxt;

  // 3-entry circular buffer; rd_ptr is the head, cnt the occupancy
  logic [DATA_WIDTH-1:0] buf_data [3];
  logic [KW-1:0]         buf_keep [3];
  logic                  buf_last [3];
  logic                  buf_user [3];
  logic [1:0]            rd_ptr, wr_ptr, cnt;

  logic       live;      // low in the first cycle after reset so s_tready comes out of reset at 0
  logic       got_last;  // the current frame's tlast has already been accepted
  logic [1:0] cls, cls_nxt;
  logic       push, pop, full, drop_now;
  logic [47:0] dst_mac;

  function automatic logic [1:0] slot(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Frame byte b as seen in the buffered beats (head = beat 0)
  function automatic logic [7:0] byte_dat(input int b);
    logic [1:0] k;
    k = 2'(b / 16);
    return buf_data[slot(rd_ptr, k)][(b % 16) * 8 +: 8];
  endfunction

  // Byte b exists: its beat was buffered before tlast and its keep bit is set
  function automatic logic byte_ok(input int b);
    logic [1:0] k;
    k = 2'(b / 16);
    return (k < cnt) && buf_keep[slot(rd_ptr, k)][b % 16];
  endfunction

  assign full = (cnt == 2'd3);
  assign pop  = m_tvalid && m_tready;
  assign push = s_tvalid && s_tready && (state == COLLECT || state == FORWARD);

  // Header parse over the buffered beats
  always_comb begin
    logic is_ip, is_udp;
    dst_mac = {byte_dat(0), byte_dat(1), byte_dat(2), byte_dat(3), byte_dat(4), byte_dat(5)};
    is_ip   = byte_ok(12) && byte_ok(13) && byte_ok(14) &&
              ({byte_dat(12), byte_dat(13)} == 16'h0800) && (byte_dat(14) == 8'h45);
    is_udp  = (byte_dat(23) == 8'h11);
    cls_nxt = 2'b00;
    if (is_ip && byte_ok(23)) begin
      if (!is_udp) begin
        cls_nxt = 2'b01;
      end else if (byte_ok(36) && byte_ok(37)) begin
        cls_nxt = ({byte_dat(36), byte_dat(37)} == WG_UDP_PORT) ? 2'b11 : 2'b10;
      end
    end
  end

  assign drop_now = FILTER_EN && (dst_mac != LOCAL_MAC) && (dst_mac != 48'hFFFF_FFFF_FFFF);

  // Input ready per state; FORWARD stops taking beats once this frame's tlast is in,
  // so the next frame always starts into an empty buffer
  always_comb begin
    s_tready = 1'b0;
    case (state)
      COLLECT: s_tready = live;
      FORWARD: s_tready = live && !got_last && (!full || pop);
      DROP:    s_tready = live && !got_last;
      default: s_tready = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (push && (s_tlast || cnt == 2'd2)) state_nxt = DECIDE;
      DECIDE:  state_nxt = drop_now ? DROP : FORWARD;
      FORWARD: if (pop && buf_last[rd_ptr]) state_nxt = COLLECT;
      DROP:    if (got_last || (s_tvalid && s_tready && s_tlast)) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  assign m_tvalid = (state == FORWARD) && (cnt != 2'd0);
  assign m_tdata  = buf_data[rd_ptr];
  assign m_tkeep  = buf_keep[rd_ptr];
  assign m_tlast  = m_tvalid && buf_last[rd_ptr];
  assign m_tuser  = m_tvalid ? {cls, buf_last[rd_ptr] && buf_user[rd_ptr]} : 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLLECT;
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      cnt      <= 2'd0;
      live     <= 1'b0;
      got_last <= 1'b0;
      cls      <= 2'b00;
      drop_cnt <= 16'd0;
      for (int i = 0; i < 3; i++) begin
        buf_data[i] <= '0;
        buf_keep[i] <= '0;
        buf_last[i] <= 1'b0;
        buf_user[i] <= 1'b0;
      end
    end else begin
      live  <= 1'b1;
      state <= state_nxt;
      if (push) begin
        buf_data[wr_ptr] <= s_tdata;
        buf_keep[wr_ptr] <= s_tkeep;
        buf_last[wr_ptr] <= s_tlast;
        buf_user[wr_ptr] <= s_tuser;
        wr_ptr           <= slot(wr_ptr, 2'd1);
      end
      if (pop) rd_ptr <= slot(rd_ptr, 2'd1);
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: ;
      endcase
      if (state == DECIDE) begin
        cls <= cls_nxt;
        if (drop_now) begin
          // flush the held beats; the rest of the frame is discarded in DROP
          cnt    <= 2'd0;
          rd_ptr <= 2'd0;
          wr_ptr <= 2'd0;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
      end
      if (state != COLLECT && state_nxt == COLLECT) got_last <= 1'b0;
      else if (s_tvalid && s_tready && s_tlast)    got_last <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dpe_eth_rx_classifier.sv
module tb_dpe_eth_rx_classifier;

  localparam logic [47:0] LMAC  = 48'hA2E6_3494_B583;
  localparam logic [47:0] OTHER = 48'h0200_0000_0001;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] WG    = 16'd51820;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
    logic [2:0]   u;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] s_tdata = '0;
  logic [15:0]  s_tkeep = '0;
  logic         s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic         m_tready = 1'b1;
  int           sel = 0;   // 0: filtering instance, 1: FILTER_EN=0 instance

  always #5 clk = ~clk;

  logic f_vld, n_vld;
  assign f_vld = s_tvalid && (sel == 0);
  assign n_vld = s_tvalid && (sel == 1);

  logic         f_s_tready, f_m_tvalid, f_m_tlast, n_s_tready, n_m_tvalid, n_m_tlast;
  logic [127:0] f_m_tdata, n_m_tdata;
  logic [15:0]  f_m_tkeep, n_m_tkeep, f_drop_cnt, n_drop_cnt;
  logic [2:0]   f_m_tuser, n_m_tuser;

  dpe_eth_rx_classifier #(.LOCAL_MAC(LMAC), .WG_UDP_PORT(WG), .FILTER_EN(1'b1), .DATA_WIDTH(128)) u_f (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(f_vld), .s_tready(f_s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser), .m_tdata(f_m_tdata), .m_tkeep(f_m_tkeep), .m_tvalid(f_m_tvalid),
    .m_tready(m_tready), .m_tlast(f_m_tlast), .m_tuser(f_m_tuser), .drop_cnt(f_drop_cnt));

  dpe_eth_rx_classifier #(.LOCAL_MAC(LMAC), .WG_UDP_PORT(WG), .FILTER_EN(1'b0), .DATA_WIDTH(128)) u_n (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(n_vld), .s_tready(n_s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser), .m_tdata(n_m_tdata), .m_tkeep(n_m_tkeep), .m_tvalid(n_m_tvalid),
    .m_tready(m_tready), .m_tlast(n_m_tlast), .m_tuser(n_m_tuser), .drop_cnt(n_drop_cnt));

  // View of whichever instance is currently selected
  logic         o_s_tready, o_m_tvalid, o_m_tlast;
  logic [127:0] o_m_tdata;
  logic [15:0]  o_m_tkeep, o_drop_cnt;
  logic [2:0]   o_m_tuser;
  assign o_s_tready = sel ? n_s_tready : f_s_tready;
  assign o_m_tvalid = sel ? n_m_tvalid : f_m_tvalid;
  assign o_m_tlast  = sel ? n_m_tlast  : f_m_tlast;
  assign o_m_tdata  = sel ? n_m_tdata  : f_m_tdata;
  assign o_m_tkeep  = sel ? n_m_tkeep  : f_m_tkeep;
  assign o_m_tuser  = sel ? n_m_tuser  : f_m_tuser;
  assign o_drop_cnt = sel ? n_drop_cnt : f_drop_cnt;

  int checks = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Current frame as a plain byte array
  logic [7:0] fb [0:255];
  int         flen;
  bit         fbad;

  beat_t expq [$];
  int    exp_drops [2];
  int    mode = 0;  // m_tready: 0 always 1, 1 random, 2 fixed stall pattern
  int    pc = 0;

  int obs_beats = 0, obs_frames = 0, blocked = 0;
  int first_out = 0, last_out = 0, in_cyc = 0;
  logic [1:0]  obs_cls = 2'b00;
  logic        obs_bad = 1'b0;
  logic [15:0] obs_keep = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Classification straight from the header byte rules and the frame length
  function automatic logic [1:0] model_cls();
    if (flen < 15) return 2'b00;
    if ({fb[12], fb[13]} != 16'h0800 || fb[14] != 8'h45) return 2'b00;
    if (flen < 24) return 2'b00;
    if (fb[23] != 8'h11) return 2'b01;
    if (flen < 38) return 2'b00;
    return ({fb[36], fb[37]} == WG) ? 2'b11 : 2'b10;
  endfunction

  function automatic bit model_drop(input bit filt);
    logic [47:0] mac;
    mac = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
    return filt && (mac != LMAC) && (mac != BCAST);
  endfunction

  task automatic build(input logic [47:0] mac, input logic [15:0] et, input logic [7:0] b14,
                       input logic [7:0] proto, input logic [15:0] port, input int len, input bit bad);
    for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) fb[i] = mac[47 - 8*i -: 8];
    fb[12] = et[15:8];   fb[13] = et[7:0];
    fb[14] = b14;        fb[23] = proto;
    fb[36] = port[15:8]; fb[37] = port[7:0];
    flen = len;
    fbad = bad;
  endtask

  // Records the expected output for the current frame, then drives up to max_beats beats
  task automatic send_frame(input int max_beats);
    logic [1:0] c;
    bit         dr, hs;
    int         nb, waited;
    beat_t      b;
    c  = model_cls();
    dr = model_drop(sel == 0);
    nb = (flen + 15) / 16;
    obs_beats = 0;
    if (dr) exp_drops[sel]++;
    else begin
      for (int i = 0; i < nb; i++) begin
        for (int j = 0; j < 16; j++) begin
          b.d[8*j +: 8] = fb[16*i + j];
          b.k[j]        = (16*i + j < flen);
        end
        b.l = (i == nb - 1);
        b.u = {c, b.l && fbad};
        expq.push_back(b);
      end
    end
    for (int i = 0; i < nb && i < max_beats; i++) begin
      if (mode == 1 && $urandom_range(0, 4) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      for (int j = 0; j < 16; j++) begin
        s_tdata[8*j +: 8] = fb[16*i + j];
        s_tkeep[j]        = (16*i + j < flen);
      end
      s_tlast  = (i == nb - 1);
      s_tuser  = (i == nb - 1) ? fbad : 1'($urandom);
      s_tvalid = 1'b1;
      hs = 1'b0;
      waited = 0;
      while (!hs && waited < 1000) begin
        @(negedge clk);
        hs = o_s_tready;
        @(posedge clk); #1;
        waited++;
      end
      if (!hs) begin
        checks++; fails++;
        $display("FAIL send_beat: s_tready stayed low for 1000 cycles at beat %0d", i);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        return;
      end
      if (i == 0) in_cyc = cyc;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (expq.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain_%s: %0d expected beats never appeared", tag, expq.size());
      expq.delete();
    end
    chk({"drop_cnt_", tag}, 128'(o_drop_cnt), 128'(exp_drops[sel]));
  endtask

  always @(posedge clk) begin
    #1;
    case (mode)
      0: m_tready = 1'b1;
      1: m_tready = ($urandom_range(0, 3) != 0);
      default: begin
        m_tready = (pc < 10) || (pc >= 11 && pc < 27);
        pc = (pc + 1) % 29;
      end
    endcase
  end

  // Output compare against the expected-beat queue, plus stall stability
  bit           prev_stall = 1'b0;
  logic [127:0] prev_d;
  logic [20:0]  prev_ctl;
  beat_t        e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_data", o_m_tdata, prev_d);
        chk("stall_ctl", 128'({o_m_tvalid, o_m_tlast, o_m_tuser, o_m_tkeep}), 128'(prev_ctl));
      end
      if (o_m_tvalid && m_tready) begin
        if (expq.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_beat: got data %0h with no beat expected", o_m_tdata);
        end else begin
          e = expq.pop_front();
          chk("beat_data", o_m_tdata, e.d);
          chk("beat_ctl", 128'({o_m_tkeep, o_m_tlast, o_m_tuser}), 128'({e.k, e.l, e.u}));
        end
        if (obs_beats == 0) first_out = cyc + 1;
        obs_beats++;
        obs_cls = o_m_tuser[2:1];
        if (o_m_tlast) begin
          last_out = cyc + 1;
          obs_bad  = o_m_tuser[0];
          obs_keep = o_m_tkeep;
          obs_frames++;
        end
      end
      if (s_tvalid && !o_s_tready && o_m_tvalid && !m_tready) blocked++;
      prev_stall = o_m_tvalid && !m_tready;
      prev_d     = o_m_tdata;
      prev_ctl   = {o_m_tvalid, o_m_tlast, o_m_tuser, o_m_tkeep};
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_tready"}, 128'(o_s_tready), 128'(0));
    chk({tag, "_m_tvalid"}, 128'(o_m_tvalid), 128'(0));
    chk({tag, "_m_tlast"},  128'(o_m_tlast),  128'(0));
    chk({tag, "_m_tuser"},  128'(o_m_tuser),  128'(0));
    chk({tag, "_drop_cnt"}, 128'(o_drop_cnt), 128'(0));
  endtask

  task automatic class_case(input string tag, input logic [7:0] b14, input logic [7:0] proto,
                            input logic [15:0] port, input logic [1:0] want);
    build(LMAC, 16'h0800, b14, proto, port, 170, 1'b0);
    chk({tag, "_model"}, 128'(model_cls()), 128'(want));
    send_frame(99);
    drain(tag);
    chk({tag, "_beats"}, 128'(obs_beats), 128'(11));
    chk({tag, "_class"}, 128'(obs_cls), 128'(want));
  endtask

  initial begin
    exp_drops[0] = 0;
    exp_drops[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Accept path: WireGuard frame, 11 beats, last tkeep 0x03FF
    class_case("accept", 8'h45, 8'h11, WG, 2'b11);
    chk("accept_last_keep", 128'(obs_keep), 128'(16'h03FF));
    chk("accept_latency", 128'(first_out - in_cyc), 128'(4));
    chk("accept_throughput", 128'(last_out - first_out), 128'(10));

    class_case("cls_ihl", 8'h05, 8'h11, WG, 2'b00);
    class_case("cls_tcp", 8'h45, 8'h06, WG, 2'b01);
    class_case("cls_udp", 8'h45, 8'h11, 16'h1234, 2'b10);

    // Filter: unicast mismatch dropped, then a good frame passes
    build(OTHER, 16'h0800, 8'h45, 8'h11, WG, 170, 1'b0);
    chk("filter_model", 128'(model_drop(1'b1)), 128'(1));
    send_frame(99);
    drain("filter");
    chk("filter_beats", 128'(obs_beats), 128'(0));
    chk("filter_cnt", 128'(o_drop_cnt), 128'(1));
    class_case("after_drop", 8'h45, 8'h11, WG, 2'b11);

    build(BCAST, 16'h0800, 8'h45, 8'h11, WG, 170, 1'b0);
    send_frame(99);
    drain("bcast");
    chk("bcast_beats", 128'(obs_beats), 128'(11));

    // Filter disabled instance forwards the unicast mismatch
    sel = 1;
    build(OTHER, 16'h0800, 8'h45, 8'h06, WG, 170, 1'b0);
    send_frame(99);
    drain("nofilter");
    chk("nofilter_beats", 128'(obs_beats), 128'(11));
    chk("nofilter_class", 128'(obs_cls), 128'(2'b01));
    sel = 0;

    // Backpressure: fixed stall pattern over three back-to-back frames
    mode = 2; pc = 0; blocked = 0;
    begin
      int f0;
      f0 = obs_frames;
      for (int i = 0; i < 3; i++) begin
        build(LMAC, 16'h0800, 8'h45, 8'h11, (i == 1) ? 16'h0035 : WG, 170, 1'b0);
        send_frame(99);
      end
      drain("bp");
      chk("bp_frames", 128'(obs_frames - f0), 128'(3));
      chk("bp_input_blocked", 128'(blocked > 0), 128'(1));
    end
    mode = 0;

    // Short frames
    build(LMAC, 16'h0800, 8'h45, 8'h11, WG, 16, 1'b1);
    chk("one_beat_model", 128'(model_cls()), 128'(2'b00));
    send_frame(99);
    drain("one_beat");
    chk("one_beat_beats", 128'(obs_beats), 128'(1));
    chk("one_beat_class", 128'(obs_cls), 128'(2'b00));
    chk("one_beat_bad", 128'(obs_bad), 128'(1));

    build(LMAC, 16'h0800, 8'h45, 8'h11, WG, 32, 1'b0);
    chk("two_beat_model", 128'(model_cls()), 128'(2'b00));
    send_frame(99);
    drain("two_beat");
    chk("two_beat_beats", 128'(obs_beats), 128'(2));
    chk("two_beat_class", 128'(obs_cls), 128'(2'b00));

    // Reset after 5 of 11 beats
    build(LMAC, 16'h0800, 8'h45, 8'h11, WG, 170, 1'b0);
    send_frame(5);
    rst_n = 1'b0;
    expq.delete();
    exp_drops[0] = 0;
    exp_drops[1] = 0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    class_case("post_reset", 8'h45, 8'h11, WG, 2'b11);

    // Randomized frames in groups, each group on one instance
    mode = 1;
    for (int g = 0; g < 6; g++) begin
      sel = ($urandom_range(0, 3) == 0) ? 1 : 0;
      for (int f = 0; f < 10; f++) begin
        logic [47:0] mac;
        case ($urandom_range(0, 3))
          0: mac = LMAC;
          1: mac = BCAST;
          2: mac = OTHER;
          default: mac = {16'($urandom), 32'($urandom)};
        endcase
        build(mac,
              ($urandom_range(0, 3) != 0) ? 16'h0800 : 16'h86DD,
              ($urandom_range(0, 3) != 0) ? 8'h45 : 8'h46,
              ($urandom_range(0, 2) != 0) ? 8'h11 : 8'h06,
              ($urandom_range(0, 1) != 0) ? WG : 16'($urandom),
              $urandom_range(1, 190),
              1'($urandom));
        send_frame(99);
      end
      drain("rand");
    end
    mode = 0;
    sel = 0;
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1);
  end

endmodule
